// File: rtl/sar_pkg.sv
// sar_pkg: shared definitions for the SAR conversion sequencer.
//   - sar_state_e   : sequencer states
//   - N_BITS_DEF    : default SAR resolution
//   - SAMPLE_CYC_DEF: default sample/hold duration in cycles
//   - CONV_LATENCY  : start-to-result_valid latency (single conversion)
//   - cnt_w()       : counter width helper that never returns 0
package sar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        CONVERT,
        CAPTURE,
        DONE
    } sar_state_e;

    localparam int N_BITS_DEF     = 8;
    localparam int SAMPLE_CYC_DEF = 4;
    localparam int CONV_LATENCY   = SAMPLE_CYC_DEF + N_BITS_DEF + 2;

    // $clog2 of 1 is 0; keep at least one bit so degenerate sizes still build.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sar_avg_acc.sv
// sar_avg_acc: four-pass averaging accumulator for the SAR sequencer.
// Used only when SAR_AVG4_EN is defined.
// Ports:
//   clk, reset   - clock, synchronous active-low reset (clears sum and pass count)
//   capture      - high in a CAPTURE cycle; folds code into the running sum
//   code         - SAR code being captured
//   last         - the current capture is the 4th pass
//   avg          - (sum of previous passes + code) >> 2, valid alongside last
module sar_avg_acc #(
    parameter int N_BITS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic [N_BITS-1:0] code,
    output logic              last,
    output logic [N_BITS-1:0] avg
);

    logic [N_BITS+1:0] acc;
    logic [N_BITS+1:0] sum;
    logic [1:0]        pass;

    // Sum including the code being captured now, so the 4th pass needs no
    // extra cycle to produce the average.
    assign sum  = acc + {2'b00, code};
    assign avg  = sum[N_BITS+1:2];
    assign last = (pass == 2'd3);

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc  <= '0;
            pass <= '0;
        end else if (capture) begin
            if (last) begin
                acc  <= '0;
                pass <= '0;
            end else begin
                acc  <= sum;
                pass <= pass + 2'd1;
            end
        end
    end

endmodule

// File: rtl/sar_conv_ctrl.sv
// sar_conv_ctrl: SAR ADC conversion sequencer.
// On start: holds sample_en for SAMPLE_CYCLES, pulses sar_clr on the first
// sample cycle, strobes sar_step once per bit, captures sar_code and offers
// it on a valid/ready result port. A start that cannot be accepted sets the
// sticky overrun flag (cleared only by reset).
// Optional: define SAR_AVG4_EN to run four passes per start and report the
// truncated mean of the four captured codes.
// Ports:
//   clk, reset     - clock, synchronous active-low reset
//   start          - conversion request
//   sar_code       - code from the SAR register stage
//   sample_en      - sample/hold switch enable
//   sar_clr        - one-cycle SAR register re-init pulse
//   sar_step       - bit-trial strobe
//   busy           - sequencer not idle
//   result         - captured code
//   result_valid   - result available
//   result_ready   - consumer accepts result
//   overrun        - sticky dropped-start flag
module sar_conv_ctrl
    import sar_pkg::*;
#(
    parameter int N_BITS        = N_BITS_DEF,
    parameter int SAMPLE_CYCLES = SAMPLE_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_BITS-1:0] sar_code,
    output logic              sample_en,
    output logic              sar_clr,
    output logic              sar_step,
    output logic              busy,
    output logic [N_BITS-1:0] result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              overrun
);

    localparam int BW = cnt_w(N_BITS);
    localparam int SW = cnt_w(SAMPLE_CYCLES + 1);

    localparam logic [BW-1:0] BIT_MAX  = BW'(N_BITS - 1);
    localparam logic [SW-1:0] SAMP_END = SW'(SAMPLE_CYCLES);

    sar_state_e    state;
    logic [BW-1:0] bit_cnt;
    logic [SW-1:0] samp_cnt;   // counts sample cycles already spent, 1-based

`ifdef SAR_AVG4_EN
    logic              acc_last;
    logic [N_BITS-1:0] acc_avg;

    sar_avg_acc #(.N_BITS(N_BITS)) u_acc (
        .clk     (clk),
        .reset   (reset),
        .capture (state == CAPTURE),
        .code    (sar_code),
        .last    (acc_last),
        .avg     (acc_avg)
    );
`endif

    // Outputs are registered: each transition also loads the output values
    // that belong to the destination state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            bit_cnt      <= BIT_MAX;
            samp_cnt     <= '0;
            sample_en    <= 1'b0;
            sar_clr      <= 1'b0;
            sar_step     <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sar_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SAMPLE;
                        sample_en <= 1'b1;
                        sar_clr   <= 1'b1;
                        busy      <= 1'b1;
                        samp_cnt  <= SW'(1);
                    end
                end
                SAMPLE: begin
                    if (start) overrun <= 1'b1;
                    if (samp_cnt == SAMP_END) begin
                        state     <= CONVERT;
                        sample_en <= 1'b0;
                        sar_step  <= 1'b1;
                        bit_cnt   <= BIT_MAX;
                    end else begin
                        samp_cnt <= samp_cnt + 1'b1;
                    end
                end
                CONVERT: begin
                    if (start) overrun <= 1'b1;
                    if (bit_cnt == '0) begin
                        state    <= CAPTURE;
                        sar_step <= 1'b0;
                        bit_cnt  <= BIT_MAX;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    if (start) overrun <= 1'b1;
`ifdef SAR_AVG4_EN
                    if (acc_last) begin
                        result       <= acc_avg;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end else begin
                        // next averaging pass starts with a fresh sample
                        state     <= SAMPLE;
                        sample_en <= 1'b1;
                        sar_clr   <= 1'b1;
                        samp_cnt  <= SW'(1);
                    end
`else
                    result       <= sar_code;
                    result_valid <= 1'b1;
                    state        <= DONE;
`endif
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        if (start) begin
                            // back-to-back: skip IDLE entirely
                            state     <= SAMPLE;
                            sample_en <= 1'b1;
                            sar_clr   <= 1'b1;
                            samp_cnt  <= SW'(1);
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (start) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    sample_en    <= 1'b0;
                    sar_step     <= 1'b0;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
